// File: rtl/aud_pkg.sv
// Shared types and constants for the audio playback DSP and recorder.
package aud_pkg;

    localparam int unsigned ADDR_W  = 20;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned SPEED_W = 3;
    localparam int unsigned FACT_W  = SPEED_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CALC,
        S_PAUSE
    } state_e;

    typedef enum logic [1:0] {
        NORMAL,
        FAST,
        SLOW0,
        SLOW1
    } mode_e;

    // Fast wins over linear-interpolated slow, which wins over zero-order-hold slow.
    function automatic mode_e mode_sel(input logic fast, input logic slow1, input logic slow0);
        mode_e m;
        m = NORMAL;
        if (fast) begin
            m = FAST;
        end else if (slow1) begin
            m = SLOW1;
        end else if (slow0) begin
            m = SLOW0;
        end
        return m;
    endfunction

endpackage

// File: rtl/aud_interp.sv
// Linear interpolation between two samples: prev + (cur - prev) * (k + 1) / F,
// signed, truncated toward zero.
module aud_interp #(
    parameter int unsigned DATA_W = aud_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] prev_i,
    input  logic [DATA_W-1:0] cur_i,
    input  logic [2:0]        k_i,
    input  logic [3:0]        f_i,
    output logic [DATA_W-1:0] sample_o
);

    // Wide enough for (cur - prev) * 8 without overflow.
    localparam int unsigned PW = DATA_W + 5;

    logic signed [PW-1:0] diff_c;
    logic signed [PW-1:0] mult_c;
    logic signed [PW-1:0] div_c;
    logic signed [PW-1:0] prod_c;

    always_comb begin
        diff_c   = PW'($signed(cur_i)) - PW'($signed(prev_i));
        mult_c   = PW'({1'b0, k_i}) + PW'(1);
        div_c    = PW'({1'b0, f_i});
        prod_c   = diff_c * mult_c;
        sample_o = DATA_W'(prev_c_add(prev_i, prod_c / div_c));
    end

    function automatic logic signed [PW-1:0] prev_c_add(input logic [DATA_W-1:0] p,
                                                        input logic signed [PW-1:0] q);
        return PW'($signed(p)) + q;
    endfunction

endmodule

// File: rtl/aud_dsp.sv
// Playback DSP: walks recorded SRAM samples once per codec LR-clock rise,
// supporting normal, fast-forward and two slow-motion modes plus pause/stop.
module aud_dsp #(
    parameter int unsigned ADDR_W = aud_pkg::ADDR_W,
    parameter int unsigned DATA_W = aud_pkg::DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_fast,
    input  logic              i_slow_0,
    input  logic              i_slow_1,
    input  logic [2:0]        i_speed,
    input  logic              i_daclrck,
    input  logic [ADDR_W-1:0] i_recd_len,
    input  logic [DATA_W-1:0] i_sram_data,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_dac_data,
    output logic              o_player_en,
    output logic              o_done
);

    import aud_pkg::*;

    // One extra bit so address + F never wraps before the length compare.
    localparam int unsigned NA_W = ADDR_W + 1;

    state_e            state_q, state_d;
    mode_e             mode_q,  mode_d;
    logic [3:0]        f_q,     f_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [2:0]        k_q,     k_d;
    logic [DATA_W-1:0] prev_q,  prev_d;
    logic [DATA_W-1:0] cur_q,   cur_d;
    logic [DATA_W-1:0] dac_q,   dac_d;
    logic              en_q,    en_d;
    logic              done_q,  done_d;
    logic              lrc_q;

    logic              lrc_rise_c;
    logic [2:0]        k_last_c;
    logic [NA_W-1:0]   next_addr_c;
    logic              adv_c;
    logic [DATA_W-1:0] interp_c;

    assign lrc_rise_c = i_daclrck & ~lrc_q;
    assign k_last_c   = 3'(f_q - 4'd1);

    aud_interp #(
        .DATA_W (DATA_W)
    ) u_interp (
        .prev_i   (prev_q),
        .cur_i    (cur_q),
        .k_i      (k_q),
        .f_i      (f_q),
        .sample_o (interp_c)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            mode_q  <= NORMAL;
            f_q     <= 4'd1;
            addr_q  <= '0;
            k_q     <= '0;
            prev_q  <= '0;
            cur_q   <= '0;
            dac_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            lrc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            f_q     <= f_d;
            addr_q  <= addr_d;
            k_q     <= k_d;
            prev_q  <= prev_d;
            cur_q   <= cur_d;
            dac_q   <= dac_d;
            en_q    <= en_d;
            done_q  <= done_d;
            lrc_q   <= i_daclrck;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        f_d         = f_q;
        addr_d      = addr_q;
        k_d         = k_q;
        prev_d      = prev_q;
        cur_d       = cur_q;
        dac_d       = dac_q;
        done_d      = 1'b0;
        next_addr_c = {1'b0, addr_q};
        adv_c       = 1'b0;

        if ((state_q != S_IDLE) && i_stop) begin
            state_d = S_IDLE;
            addr_d  = '0;
            k_d     = '0;
            prev_d  = '0;
            dac_d   = '0;
        end else if ((state_q != S_IDLE) && i_pause) begin
            state_d = S_PAUSE;
            dac_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    dac_d = '0;
                    if (i_start) begin
                        addr_d = '0;
                        prev_d = '0;
                        k_d    = '0;
                        if (i_recd_len == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end

                // Mode and factor are frozen for the whole sample period.
                S_WAIT: begin
                    if (lrc_rise_c) begin
                        state_d = S_CALC;
                        cur_d   = i_sram_data;
                        mode_d  = mode_sel(i_fast, i_slow_1, i_slow_0);
                        f_d     = {1'b0, i_speed} + 4'd1;
                    end
                end

                S_CALC: begin
                    case (mode_q)
                        FAST: begin
                            next_addr_c = {1'b0, addr_q} + NA_W'(f_q);
                            adv_c       = 1'b1;
                        end
                        SLOW0, SLOW1: begin
                            if (k_q == k_last_c) begin
                                next_addr_c = {1'b0, addr_q} + NA_W'(1);
                                adv_c       = 1'b1;
                                k_d         = '0;
                            end else begin
                                k_d = k_q + 3'd1;
                            end
                        end
                        default: begin
                            next_addr_c = {1'b0, addr_q} + NA_W'(1);
                            adv_c       = 1'b1;
                        end
                    endcase

                    dac_d = (mode_q == SLOW1) ? interp_c : cur_q;
                    if (adv_c) begin
                        prev_d = cur_q;
                    end

                    // Last sample still goes out; position rewinds for the next start.
                    if (next_addr_c >= {1'b0, i_recd_len}) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        addr_d  = '0;
                        k_d     = '0;
                        prev_d  = '0;
                    end else begin
                        state_d = S_WAIT;
                        addr_d  = next_addr_c[ADDR_W-1:0];
                    end
                end

                S_PAUSE: begin
                    dac_d = '0;
                    if (i_start) begin
                        state_d = S_WAIT;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        en_d = (state_d == S_WAIT) || (state_d == S_CALC);
    end

    assign o_sram_addr = addr_q;
    assign o_dac_data  = dac_q;
    assign o_player_en = en_q;
    assign o_done      = done_q;

endmodule
